spike_rate_logger: RTL and testbench
====================================

Name: spike_rate_logger

Overview:
Downstream consumer of the neuron stage's raw spike output. Edge-detects spikes in the fast clock domain and counts them per simulation window (one window per sim tick). Each closed window count is pushed into an on-chip FIFO. The host drains the FIFO as 16-bit words through a block-throttled pipe-out endpoint, giving a lossless per-millisecond firing-rate record.

Parameters:
CNT_W, 32, spike counter / logged sample width (must be 32: two 16-bit words)
DEPTH_LOG2, 9, FIFO depth = 2^DEPTH_LOG2 samples
BLOCK_WORDS, 256, words that must be buffered before rd_ready asserts

Ports:
clk  in  1  fast system clock (clk1 domain); all logic on rising edge
reset  in  1  synchronous, active-low reset
spike  in  1  raw spike level/pulse, already synchronous to clk
tick  in  1  one-cycle strobe closing the current window (sim_clk rising edge, synchronised upstream)
rd_en  in  1  pipe-out read strobe, one word per asserted cycle
rd_data  out  16  word returned for the previous cycle's rd_en
rd_ready  out  1  buffered words >= BLOCK_WORDS
words_avail  out  16  words currently readable (saturating)
cur_count  out  CNT_W  live count of the open window
overflow  out  1  sticky: a sample was dropped because the FIFO was full
clr_ovf  in  1  one-cycle clear of overflow

Behaviour:
- Reset (reset==0 at a clk edge):
  - cur_count=0, rd_data=0, rd_ready=0, words_avail=0, overflow=0.
  - FIFO emptied, half-word pointer=low, spike edge register=0.
  - Reset mid-window discards the partial count and all buffered samples.
- Spike detection: rising edge of spike (spike & ~spike_d) increments cur_count; a held-high level counts once.
- Counter saturates at 2^CNT_W-1; no wrap.
- Window close on tick:
  - The pushed sample = cur_count plus the edge detected in the same cycle, if any. A coincident spike belongs to the closing window.
  - cur_count is then loaded with 0.
- Push rule: if the FIFO is not full, write the sample. If full, drop it and set overflow=1. The FIFO is never overwritten.
- overflow: set/clear priority is set > clear when a drop and clr_ovf coincide.
- Read path:
  - Each sample is emitted as two words, low half [15:0] first, then high half [31:16].
  - rd_en with half=low returns the low word and toggles half. rd_en with half=high returns the high word, pops the entry, and toggles half.
  - rd_data is registered and valid one clk after rd_en.
- Empty read: rd_en when words_avail==0 returns 16'h0000, changes no pointer, and sets no flag.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- A push into a FIFO that a same-cycle pop frees is accepted (full is evaluated after the pop).
- words_avail = 2*entries - (half==high ? 1 : 0). Registered; updates one cycle after push/pop.
- rd_ready = (words_avail >= BLOCK_WORDS), registered.
- States (read side): IDLE_LO, HAVE_HI. IDLE_LO→HAVE_HI on rd_en & nonempty. HAVE_HI→IDLE_LO on rd_en.

Optional Feature:
SPIKE_LOG_TIMESTAMP_EN
- Defined:
  - Each entry carries a 16-bit window index (incremented on every tick, wraps 0xFFFF→0, reset to 0). The index still advances on dropped windows, so the host can detect gaps.
  - Per-sample word order is index, count[15:0], count[31:16].
  - Read FSM has three states. words_avail uses a factor of 3.
- Undefined: 2-word format as above; no index storage.

Decomposition:
- Shared package spike_log_pkg: CNT_W default, WORD_W=16, WORDS_PER_SAMPLE (2 or 3, selected by the macro), read-state encoding.
- One sub-module: sync_fifo_1clk (parameter width/depth; first-word-fall-through, inferred BRAM; full/empty/count outputs).

Test Plan:
- Reset then 5 spike edges and a tick → FIFO holds 5; reads return 0x0005 then 0x0000; words_avail goes 2→0.
- spike held high for 100 cycles, then a tick → logged count 1.
- Spike edge in the same cycle as the tick, with 3 prior edges → logged 4; next window starts at 0.
- Preload cur_count near saturation (force), then more edges → logged 0xFFFFFFFF, no wrap.
- Fill the FIFO to 2^DEPTH_LOG2 samples, then one more tick → sample dropped, overflow=1.
  - Drain one sample, tick → accepted. clr_ovf → overflow=0.
- Reset asserted mid-read (half=high) → words_avail=0, rd_ready=0, next read after refill starts at a low word.
- (SPIKE_LOG_TIMESTAMP_EN) 3 windows with counts 2,0,7 → words 0,2,0, 1,0,0, 2,7,0.

Source files
------------

// File: rtl/spike_rate_logger_pkg.sv
// Shared widths and read-side state encoding for the spike rate logger.
// SPIKE_LOG_TIMESTAMP_EN adds a 16-bit window index word ahead of each sample.
package spike_log_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int WORD_W    = 16;
    localparam int IDX_W     = 16;

`ifdef SPIKE_LOG_TIMESTAMP_EN
    localparam int WORDS_PER_SAMPLE = 3;
    // State value equals the number of head-sample words already handed out.
    typedef enum logic [1:0] {
        IDLE_IDX = 2'd0,
        HAVE_LO  = 2'd1,
        HAVE_HI  = 2'd2
    } rd_state_t;
    localparam rd_state_t RD_START = IDLE_IDX;
`else
    localparam int WORDS_PER_SAMPLE = 2;
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        HAVE_HI = 2'd1
    } rd_state_t;
    localparam rd_state_t RD_START = IDLE_LO;
`endif

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

endpackage

// File: rtl/spike_rate_logger_if.sv
// Host pipe-out endpoint: read strobe, registered word, block-ready and fill level.
// master = host side, slave = logger side.
interface spike_rate_logger_if;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [15:0] words_avail;

    modport master (output rd_en, input rd_data, input rd_ready, input words_avail);
    modport slave  (input rd_en, output rd_data, output rd_ready, output words_avail);
endinterface

// File: rtl/spike_rate_logger_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry visible on o_rd_dat while not empty.
// A write into a full FIFO is accepted only if a pop frees space in the same cycle.
module sync_fifo_1clk #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_dat,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_dat,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_pop;
    logic                  w_push;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_pop    = i_rd_en & ~o_empty;
    assign w_push   = i_wr_en & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2)'(1);
            if (w_push && !w_pop)      r_count <= r_count + (DEPTH_LOG2+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (DEPTH_LOG2+1)'(1);
        end
    end
endmodule

// File: rtl/spike_rate_logger.sv
// Counts spike rising edges per tick window and logs each window count into a FIFO drained as 16-bit words.
// SPIKE_LOG_TIMESTAMP_EN: each sample also carries a 16-bit window index, emitted first.
module spike_rate_logger
    import spike_log_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEPTH_LOG2  = 9,
    parameter int BLOCK_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike,
    input  logic             tick,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] cur_count,
    output logic             overflow,
    spike_rate_logger_if.slave pipe
);
`ifdef SPIKE_LOG_TIMESTAMP_EN
    localparam int FIFO_W = CNT_W + IDX_W;
`else
    localparam int FIFO_W = CNT_W;
`endif

    logic                r_spike_d;
    logic [CNT_W-1:0]    r_cur_count;
    logic                r_overflow;
    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    logic [15:0]         r_rd_data;
    logic [15:0]         r_words_avail;
    logic                r_rd_ready;

    logic                w_edge;
    logic [CNT_W-1:0]    w_sample_cnt;
    logic [FIFO_W-1:0]   w_fifo_wdat;
    logic [FIFO_W-1:0]   w_fifo_rdat;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DEPTH_LOG2:0] w_fifo_count;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;
    logic [15:0]         w_word;
    int                  w_avail;

    assign w_edge       = spike & ~r_spike_d;
    // A spike edge coincident with tick is folded into the closing sample.
    assign w_sample_cnt = (w_edge && !(&r_cur_count)) ? r_cur_count + CNT_W'(1) : r_cur_count;
    assign w_push_ok    = tick & (~w_fifo_full | w_pop);
    assign w_drop       = tick & w_fifo_full & ~w_pop;

`ifdef SPIKE_LOG_TIMESTAMP_EN
    logic [IDX_W-1:0] r_win_idx;
    assign w_fifo_wdat = {r_win_idx, w_sample_cnt};

    always_ff @(posedge clk) begin
        if (!reset)    r_win_idx <= '0;
        else if (tick) r_win_idx <= r_win_idx + 16'd1;
    end
`else
    assign w_fifo_wdat = w_sample_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_spike_d   <= 1'b0;
            r_cur_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_spike_d   <= spike;
            r_cur_count <= tick ? '0 : w_sample_cnt;
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
        end
    end

    sync_fifo_1clk #(.WIDTH(FIFO_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (tick),
        .i_wr_dat (w_fifo_wdat),
        .i_rd_en  (w_pop),
        .o_rd_dat (w_fifo_rdat),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_count  (w_fifo_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_word      = '0;
        case (r_state)
`ifdef SPIKE_LOG_TIMESTAMP_EN
            IDLE_IDX: begin
                w_word = w_fifo_rdat[CNT_W +: WORD_W];
                if (pipe.rd_en && !w_fifo_empty) w_state_nxt = HAVE_LO;
            end
            HAVE_LO: begin
                w_word = w_fifo_rdat[0 +: WORD_W];
                if (pipe.rd_en) w_state_nxt = HAVE_HI;
            end
            HAVE_HI: begin
                w_word = w_fifo_rdat[WORD_W +: WORD_W];
                if (pipe.rd_en) begin
                    w_state_nxt = IDLE_IDX;
                    w_pop       = 1'b1;
                end
            end
`else
            IDLE_LO: begin
                w_word = w_fifo_rdat[0 +: WORD_W];
                if (pipe.rd_en && !w_fifo_empty) w_state_nxt = HAVE_HI;
            end
            HAVE_HI: begin
                w_word = w_fifo_rdat[WORD_W +: WORD_W];
                if (pipe.rd_en) begin
                    w_state_nxt = IDLE_LO;
                    w_pop       = 1'b1;
                end
            end
`endif
            default: w_state_nxt = RD_START;
        endcase
    end

    // Fill level from post-update occupancy so the registered value tracks push/pop with one cycle of lag.
    always_comb begin
        w_avail = (int'(w_fifo_count) + int'(w_push_ok) - int'(w_pop)) * WORDS_PER_SAMPLE
                  - int'(w_state_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RD_START;
            r_rd_data     <= '0;
            r_words_avail <= '0;
            r_rd_ready    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (pipe.rd_en) r_rd_data <= w_fifo_empty ? 16'h0000 : w_word;
            r_words_avail <= sat16(w_avail);
            r_rd_ready    <= (w_avail >= BLOCK_WORDS);
        end
    end

    assign cur_count        = r_cur_count;
    assign overflow         = r_overflow;
    assign pipe.rd_data     = r_rd_data;
    assign pipe.words_avail = r_words_avail;
    assign pipe.rd_ready    = r_rd_ready;
endmodule

// File: tb/tb_spike_rate_logger.sv
// Directed bench for spike_rate_logger: edge counting, window close, saturation, overflow, read path and reset.
module tb_spike_rate_logger;
    import spike_log_pkg::*;

    localparam int WPS   = WORDS_PER_SAMPLE;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        spike;
    logic        tick;
    logic        clr_ovf;
    logic [31:0] cur_count;
    logic        overflow;
    logic [15:0] win_idx;
    logic [15:0] fill_idx0;
    logic [15:0] w;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    spike_rate_logger_if pipe();

    spike_rate_logger #(.CNT_W(32), .DEPTH_LOG2(9), .BLOCK_WORDS(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .spike     (spike),
        .tick      (tick),
        .clr_ovf   (clr_ovf),
        .cur_count (cur_count),
        .overflow  (overflow),
        .pipe      (pipe)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            spike = 1'b1; @(negedge clk);
            spike = 1'b0; @(negedge clk);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1; @(negedge clk);
        tick = 1'b0;
        win_idx = win_idx + 16'd1;
    endtask

    task automatic rd_word(output logic [15:0] d);
        pipe.rd_en = 1'b1; @(negedge clk);
        pipe.rd_en = 1'b0;
        d = pipe.rd_data;
    endtask

    task automatic read_sample(input string tag, input logic [15:0] exp_idx, input logic [31:0] exp_cnt);
        logic [15:0] d;
`ifdef SPIKE_LOG_TIMESTAMP_EN
        rd_word(d); check_eq({tag, "_idx"}, {16'h0, d}, {16'h0, exp_idx});
`else
        d = exp_idx;
`endif
        rd_word(d); check_eq({tag, "_lo"}, {16'h0, d}, {16'h0, exp_cnt[15:0]});
        rd_word(d); check_eq({tag, "_hi"}, {16'h0, d}, {16'h0, exp_cnt[31:16]});
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        win_idx = 16'h0;
    endtask

    initial begin
        reset = 1'b0; spike = 1'b0; tick = 1'b0; clr_ovf = 1'b0; pipe.rd_en = 1'b0;
        win_idx = 16'h0;
        @(negedge clk);
        apply_reset();
        check_eq("rst_cur_count", cur_count, 32'h0);
        check_eq("rst_rd_data", {16'h0, pipe.rd_data}, 32'h0);
        check_eq("rst_rd_ready", {31'h0, pipe.rd_ready}, 32'h0);
        check_eq("rst_words_avail", {16'h0, pipe.words_avail}, 32'h0);
        check_eq("rst_overflow", {31'h0, overflow}, 32'h0);

        // Five edges, one window
        pulses(5);
        check_eq("cnt5_live", cur_count, 32'd5);
        do_tick();
        check_eq("cnt5_avail", {16'h0, pipe.words_avail}, WPS);
        check_eq("cnt5_cleared", cur_count, 32'h0);
        check_eq("cnt5_not_ready", {31'h0, pipe.rd_ready}, 32'h0);
`ifdef SPIKE_LOG_TIMESTAMP_EN
        rd_word(w); check_eq("cnt5_idx", {16'h0, w}, 32'h0);
`endif
        rd_word(w); check_eq("cnt5_lo", {16'h0, w}, 32'h5);
        check_eq("cnt5_avail_mid", {16'h0, pipe.words_avail}, 32'd1);
        rd_word(w); check_eq("cnt5_hi", {16'h0, w}, 32'h0);
        check_eq("cnt5_avail_end", {16'h0, pipe.words_avail}, 32'h0);
        rd_word(w); check_eq("empty_rd_data", {16'h0, w}, 32'h0);
        check_eq("empty_rd_avail", {16'h0, pipe.words_avail}, 32'h0);

        // Held-high level counts once
        spike = 1'b1;
        repeat (100) @(negedge clk);
        spike = 1'b0;
        check_eq("held_live", cur_count, 32'd1);
        do_tick();
        read_sample("held", win_idx - 16'd1, 32'd1);

        // Edge coincident with tick belongs to the closing window
        pulses(3);
        spike = 1'b1; tick = 1'b1; @(negedge clk);
        spike = 1'b0; tick = 1'b0; win_idx = win_idx + 16'd1;
        check_eq("coinc_next_zero", cur_count, 32'h0);
        read_sample("coinc", win_idx - 16'd1, 32'd4);

        // Saturation
        force dut.r_cur_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_cur_count;
        @(negedge clk);
        pulses(5);
        check_eq("sat_live", cur_count, 32'hFFFF_FFFF);
        do_tick();
        check_eq("sat_cleared", cur_count, 32'h0);
        read_sample("sat", win_idx - 16'd1, 32'hFFFF_FFFF);

        // Fill to capacity, then drop
        fill_idx0 = win_idx;
        for (int k = 1; k <= DEPTH; k++) begin
            do_tick();
            if (k == 127 || k == 128)
                check_eq($sformatf("fill_ready_%0d", k), {31'h0, pipe.rd_ready},
                         ((k * WPS) >= 256) ? 32'd1 : 32'd0);
        end
        check_eq("full_avail", {16'h0, pipe.words_avail}, DEPTH * WPS);
        check_eq("full_ready", {31'h0, pipe.rd_ready}, 32'd1);
        check_eq("full_no_ovf", {31'h0, overflow}, 32'h0);
        do_tick();
        check_eq("drop_ovf", {31'h0, overflow}, 32'd1);
        check_eq("drop_avail", {16'h0, pipe.words_avail}, DEPTH * WPS);
        clr_ovf = 1'b1; do_tick(); clr_ovf = 1'b0;
        check_eq("drop_beats_clr", {31'h0, overflow}, 32'd1);

        read_sample("drain1", fill_idx0, 32'h0);
        check_eq("drain1_avail", {16'h0, pipe.words_avail}, (DEPTH - 1) * WPS);
        do_tick();
        check_eq("refill_avail", {16'h0, pipe.words_avail}, DEPTH * WPS);
        check_eq("refill_ovf_sticky", {31'h0, overflow}, 32'd1);
        clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
        check_eq("clr_ovf", {31'h0, overflow}, 32'h0);

        // Final word pop coincident with push into a full FIFO
        repeat (WPS - 1) rd_word(w);
        check_eq("pp_pre_avail", {16'h0, pipe.words_avail}, DEPTH * WPS - (WPS - 1));
        pipe.rd_en = 1'b1; tick = 1'b1; @(negedge clk);
        pipe.rd_en = 1'b0; tick = 1'b0; win_idx = win_idx + 16'd1;
        check_eq("pp_hi_word", {16'h0, pipe.rd_data}, 32'h0);
        check_eq("pp_avail", {16'h0, pipe.words_avail}, DEPTH * WPS);
        check_eq("pp_no_ovf", {31'h0, overflow}, 32'h0);

        // Reset mid-sample
        rd_word(w);
        apply_reset();
        check_eq("midrst_avail", {16'h0, pipe.words_avail}, 32'h0);
        check_eq("midrst_ready", {31'h0, pipe.rd_ready}, 32'h0);
        check_eq("midrst_cur", cur_count, 32'h0);
        pulses(2);
        do_tick();
        read_sample("midrst_refill", 16'h0, 32'd2);

`ifdef SPIKE_LOG_TIMESTAMP_EN
        apply_reset();
        pulses(2); do_tick();
        do_tick();
        pulses(7); do_tick();
        read_sample("ts_w0", 16'd0, 32'd2);
        read_sample("ts_w1", 16'd1, 32'd0);
        read_sample("ts_w2", 16'd2, 32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
